// File: rtl/pc_pkg.sv
// pc_pkg -- shared constants, types and helpers for the fetch-PC generator.
//   XLEN_DEF / RESET_VEC_DEF : default PC width and reset vector
//   ILEN_BYTES               : sequential fetch increment
//   CNT_*                    : 2-bit saturating branch counter encoding
//   npc_sel_e                : next-PC source selection
//   cnt_next()               : saturating counter update helper
package pc_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int          ILEN_BYTES    = 4;

    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

    typedef enum logic [2:0] {
        NPC_SEQ      = 3'd0,
        NPC_PRED     = 3'd1,
        NPC_HOLD     = 3'd2,
        NPC_REDIRECT = 3'd3,
        NPC_TRAP     = 3'd4
    } npc_sel_e;

    // Saturating increment on taken, decrement on not-taken.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == CNT_STRONG_T) ? CNT_STRONG_T : cnt + 2'd1;
        end else begin
            res = (cnt == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// pc_btb -- direct-mapped branch target buffer.
//   Lookup port : lookup_pc -> pred_taken, pred_target (combinational, reads
//                 pre-update contents when an update hits the same index)
//   Update port : upd_valid, upd_pc, upd_target, upd_taken (written at clk edge)
//   rst_n       : asynchronous active-low clear of all valid bits
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [DEPTH-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r    [DEPTH];
    logic [XLEN-1:0]   target_r [DEPTH];
    logic [1:0]        cnt_r    [DEPTH];

    logic [IDX_W-1:0]  lk_idx_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic [IDX_W-1:0]  up_idx_s;
    logic [TAG_W-1:0]  up_tag_s;
    logic              up_hit_s;
    logic              unused_low_s;

    assign lk_idx_s = lookup_pc[IDX_W+1:2];
    assign lk_tag_s = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[XLEN-1:IDX_W+2];
    // Instruction addresses are word aligned; the low bits carry no index/tag info.
    assign unused_low_s = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup: hit on valid entry with matching tag, predict taken when counter is in the upper half.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = target_r[lk_idx_s];
        if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
            pred_taken = cnt_r[lk_idx_s][1];
        end else begin
            pred_taken = 1'b0;
        end
    end

    assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

    // Valid bits: cleared asynchronously, set when a taken branch misses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (upd_valid && !up_hit_s && upd_taken) begin
            valid_r[up_idx_s] <= 1'b1;
        end
    end

    // Entry payload (tag, target, counter); contents are meaningless until valid.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (up_hit_s) begin
                cnt_r[up_idx_s] <= cnt_next(cnt_r[up_idx_s], upd_taken);
                if (upd_taken) begin
                    target_r[up_idx_s] <= upd_target;
                end
            end else if (upd_taken) begin
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= upd_target;
                cnt_r[up_idx_s]    <= CNT_WEAK_T;
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit -- fetch PC register and next-PC selection.
// Priority: trap > redirect > stall > BTB prediction > pc+4.
// Optional BTB enabled with macro PC_BTB_EN; without it pred_taken_f is 0 and
// the upd_* ports are ignored.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall_f                         hold PC
//   redirect_valid/_target/_jalr    EX-resolved taken control transfer
//   trap_valid, trap_vec            trap request and handler address
//   upd_valid/_pc/_target/_taken    branch outcome update for the BTB
//   pc_f, pc_plus4_f                fetch PC (registered) and pc_f+4
//   pred_taken_f                    BTB predicts taken for pc_f
//   flush_fd                        flush IF/ID and ID/EX
//   misalign_err                    misaligned redirect target (registered)
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter int              BTB_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_f,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            redirect_jalr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus4_f,
    output logic            pred_taken_f,
    output logic            flush_fd,
    output logic            misalign_err
);

    logic [XLEN-1:0] pc_f_r;
    logic            misalign_err_r;
    logic [XLEN-1:0] redir_tgt_s;
    logic [XLEN-1:0] trap_tgt_s;
    logic            redir_misaligned_s;
    logic            pred_hit_s;
    logic [XLEN-1:0] pred_target_s;
    logic [XLEN-1:0] pc_next_s;
    npc_sel_e        sel_s;

    assign pc_f         = pc_f_r;
    assign misalign_err = misalign_err_r;
    // Natural XLEN-bit addition wraps modulo 2^XLEN.
    assign pc_plus4_f   = pc_f_r + XLEN'(ILEN_BYTES);
    assign flush_fd     = trap_valid | redirect_valid;
    assign pred_taken_f = pred_hit_s;

    // jalr clears bit 0 before the alignment check; trap vectors are forced word aligned.
    assign redir_tgt_s        = redirect_jalr ? (redirect_target & ~XLEN'(1)) : redirect_target;
    assign redir_misaligned_s = |redir_tgt_s[1:0];
    assign trap_tgt_s         = trap_vec & ~XLEN'(3);

`ifdef PC_BTB_EN
    pc_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc   (pc_f_r),
        .pred_taken  (pred_hit_s),
        .pred_target (pred_target_s),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken)
    );
`else
    localparam int unused_btb_depth = BTB_DEPTH;
    logic unused_upd_s;

    assign pred_hit_s    = 1'b0;
    assign pred_target_s = {XLEN{1'b0}};
    assign unused_upd_s  = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

    // Next-PC source selection in priority order.
    always_comb begin
        sel_s = NPC_SEQ;
        if (trap_valid) begin
            sel_s = NPC_TRAP;
        end else if (redirect_valid) begin
            // A misaligned redirect target is refused: the PC holds and a fault is flagged.
            sel_s = redir_misaligned_s ? NPC_HOLD : NPC_REDIRECT;
        end else if (stall_f) begin
            sel_s = NPC_HOLD;
        end else if (pred_hit_s) begin
            sel_s = NPC_PRED;
        end else begin
            sel_s = NPC_SEQ;
        end
    end

    // Next-PC multiplexer.
    always_comb begin
        pc_next_s = pc_plus4_f;
        case (sel_s)
            NPC_TRAP:     pc_next_s = trap_tgt_s;
            NPC_REDIRECT: pc_next_s = redir_tgt_s;
            NPC_HOLD:     pc_next_s = pc_f_r;
            NPC_PRED:     pc_next_s = pred_target_s;
            NPC_SEQ:      pc_next_s = pc_plus4_f;
            default:      pc_next_s = pc_plus4_f;
        endcase
    end

    // PC register and one-cycle misalignment fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_r         <= RESET_VEC;
            misalign_err_r <= 1'b0;
        end else begin
            pc_f_r         <= pc_next_s;
            misalign_err_r <= !trap_valid && redirect_valid && redir_misaligned_s;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit -- self-checking bench for pc_next_unit.
// Expected PC / fault values are queued when a cycle's stimulus is applied and
// compared after the following rising edge. Builds with or without PC_BTB_EN.
module tb_pc_next_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_jalr;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        pred_taken_f;
    logic        flush_fd;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

`ifdef PC_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    pc_next_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_f         (stall_f),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_jalr   (redirect_jalr),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .pc_f            (pc_f),
        .pc_plus4_f      (pc_plus4_f),
        .pred_taken_f    (pred_taken_f),
        .flush_fd        (flush_fd),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall_f         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        redirect_jalr   = 1'b0;
        trap_valid      = 1'b0;
        trap_vec        = 32'h0;
        upd_valid       = 1'b0;
        upd_pc          = 32'h0;
        upd_target      = 32'h0;
        upd_taken       = 1'b0;
    endtask

    // Queue the expectation for the current stimulus, clock once, then compare.
    task automatic tick(input string tag, input logic [31:0] exp_pc, input logic exp_mis);
        exp_t e;
        e.tag = tag;
        e.pc  = exp_pc;
        e.mis = exp_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, "_pc"}, pc_f, e.pc);
        check_eq({e.tag, "_mis"}, {31'b0, misalign_err}, {31'b0, e.mis});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        // Reset state.
        check_eq("rst_pc", pc_f, 32'h0);
        check_eq("rst_mis", {31'b0, misalign_err}, 32'h0);
        check_eq("rst_flush", {31'b0, flush_fd}, 32'h0);
        check_eq("rst_pred", {31'b0, pred_taken_f}, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("first_fetch", pc_f, 32'h0);
        check_eq("first_plus4", pc_plus4_f, 32'h4);

        // Sequential fetch after reset release.
        tick("seq1", 32'h4, 1'b0);
        tick("seq2", 32'h8, 1'b0);
        tick("seq3", 32'hC, 1'b0);
        tick("seq4", 32'h10, 1'b0);

        // Stall holds the PC for three cycles.
        stall_f = 1'b1;
        #1;
        check_eq("stall_flush", {31'b0, flush_fd}, 32'h0);
        for (int i = 0; i < 3; i++) tick("stall", 32'h10, 1'b0);

        // Redirect overrides the stall.
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        check_eq("redir_flush", {31'b0, flush_fd}, 32'h1);
        tick("redir_stall", 32'h100, 1'b0);
        idle();
        #1;
        check_eq("plus4_100", pc_plus4_f, 32'h104);
        check_eq("idle_flush", {31'b0, flush_fd}, 32'h0);

        // jalr clears bit 0: 0x201 -> 0x200.
        redirect_valid  = 1'b1;
        redirect_jalr   = 1'b1;
        redirect_target = 32'h201;
        tick("jalr_201", 32'h200, 1'b0);

        // Misaligned redirect holds PC and flags one cycle.
        redirect_jalr   = 1'b0;
        redirect_target = 32'h202;
        #1;
        check_eq("mis_flush", {31'b0, flush_fd}, 32'h1);
        tick("mis_202", 32'h200, 1'b1);
        idle();
        tick("mis_clear", 32'h204, 1'b0);

        // jalr 0x203 masks to 0x202, still misaligned.
        redirect_valid  = 1'b1;
        redirect_jalr   = 1'b1;
        redirect_target = 32'h203;
        tick("jalr_203", 32'h204, 1'b1);
        idle();
        tick("mis_clear2", 32'h208, 1'b0);

        // Trap beats redirect and stall; trap_vec low bits ignored.
        trap_valid      = 1'b1;
        trap_vec        = 32'h83;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        stall_f         = 1'b1;
        #1;
        check_eq("trap_flush", {31'b0, flush_fd}, 32'h1);
        tick("trap", 32'h80, 1'b0);
        idle();
        tick("after_trap", 32'h84, 1'b0);

        // Wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick("to_top", 32'hFFFF_FFFC, 1'b0);
        idle();
        #1;
        check_eq("plus4_wrap", pc_plus4_f, 32'h0);
        tick("wrap", 32'h0, 1'b0);

        // Two taken updates for branch at 0x40 -> 0x400.
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_target = 32'h400;
        upd_taken  = 1'b1;
        tick("upd_t1", 32'h4, 1'b0);
        tick("upd_t2", 32'h8, 1'b0);
        idle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick("go_40", 32'h40, 1'b0);
        idle();
        #1;
        check_eq("pred_40", {31'b0, pred_taken_f}, {31'b0, BTB_ON});

        // Not-taken update in the same cycle as the lookup: prediction uses old counter.
        upd_valid  = 1'b1;
        upd_pc     = 32'h40;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        tick("pred_next", BTB_ON ? 32'h400 : 32'h44, 1'b0);
        tick("upd_nt2", BTB_ON ? 32'h404 : 32'h48, 1'b0);
        idle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick("back_40", 32'h40, 1'b0);
        idle();
        #1;
        check_eq("pred_off", {31'b0, pred_taken_f}, 32'h0);
        tick("seq_44", 32'h44, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, the PC/address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, the PC value loaded at reset.
REQ-003 SHALL have parameter BTB_DEPTH, default 8, the BTB entry count (power of two, at least 2).
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: stall_f  input  1  hold the PC (load-use hazard).
REQ-007 SHALL have ports: redirect_valid  input  1  taken jal/jalr/branch resolved in EX.
REQ-008 SHALL have ports: redirect_target  input  XLEN  EX-computed target (ALU result).
REQ-009 SHALL have ports: redirect_jalr  input  1  redirect originates from jalr.
REQ-010 SHALL have ports: trap_valid  input  1  trap request.
REQ-011 SHALL have ports: trap_vec  input  XLEN  trap handler address.
REQ-012 SHALL have ports: upd_valid  input  1  branch outcome update from EX.
REQ-013 SHALL have ports: upd_pc  input  XLEN  PC of the resolved branch.
REQ-014 SHALL have ports: upd_target  input  XLEN  resolved target.
REQ-015 SHALL have ports: upd_taken  input  1  resolved direction.
REQ-016 SHALL have ports: pc_f  output  XLEN  current fetch PC (registered).
REQ-017 SHALL have ports: pc_plus4_f  output  XLEN  pc_f+4 (combinational).
REQ-018 SHALL have ports: pred_taken_f  output  1  the BTB predicts taken for pc_f.
REQ-019 SHALL have ports: flush_fd  output  1  flush the IF/ID and ID/EX stages.
REQ-020 SHALL have ports: misalign_err  output  1  misaligned-target fault (registered).

Function
REQ-021 SHALL select the next PC with priority trap_valid > redirect_valid > stall_f > BTB prediction > pc_f+4.
REQ-022 SHALL clear bit 0 of redirect_target when redirect_jalr=1, before the alignment check.
REQ-023 SHALL, on a redirect whose masked target has bits[1:0]!=0, hold the PC, set misalign_err for exactly the next cycle, and assert flush_fd.
REQ-024 SHALL drive flush_fd combinationally high in any cycle with trap_valid or redirect_valid, regardless of stall_f.
REQ-025 SHALL override stall_f with trap or redirect; the PC loads the new target in the same edge.
REQ-026 SHALL compute pc_plus4_f modulo 2^XLEN (0xFFFF_FFFC+4 = 0x0000_0000), and sequential fetch SHALL wrap the same way.
REQ-027 SHALL ignore trap_vec bits[1:0] (force them to 0).
REQ-028 SHALL index the BTB by pc[log2(BTB_DEPTH)+1:2], tag it with the remaining upper bits, and give each entry a valid bit, target and 2-bit saturating counter.
REQ-029 SHALL assert pred_taken_f when the entry is valid, the tag matches and counter>=2; the next PC is then the stored target.
REQ-030 SHALL handle an update on an entry miss as follows: allocate only if upd_taken (counter=2, valid=1), otherwise no change.
REQ-031 SHALL handle an update on an entry hit as follows: counter +1 if taken, -1 if not, saturating at 3 and 0; target rewritten when taken.
REQ-032 SHALL return the pre-update contents for a lookup and update to the same index in the same cycle.

Reset
REQ-033 SHALL, while rst_n=0, set pc_f=RESET_VEC, misalign_err=0 and all BTB valid bits=0 asynchronously; counters and targets are don't-care.
REQ-034 SHALL derive flush_fd and pred_taken_f only from inputs and cleared state during reset, so both are 0.
REQ-035 SHALL make the first post-reset fetch RESET_VEC, followed by RESET_VEC+4 if not stalled.

Configuration
REQ-036 SHALL, with macro PC_BTB_EN defined, instantiate the BTB as specified above.
REQ-037 SHALL, without PC_BTB_EN, tie pred_taken_f=0, instantiate no BTB storage, and keep the upd_* ports present but ignored.

Structure
REQ-038 SHALL place XLEN default, RESET_VEC default, ILEN_BYTES=4 and the 2-bit counter encoding constants in shared package pc_pkg.
REQ-039 SHALL implement the BTB as sub-module pc_btb (lookup port, update port, async clear), instantiated only under PC_BTB_EN.

Verification
REQ-040 SHALL cover: reset release, no stall -> pc_f sequence 0x0, 0x4, 0x8.
REQ-041 SHALL cover: stall_f=1 for 3 cycles at pc_f=0x10 -> pc_f stays 0x10; redirect_valid with target 0x100 during the stall -> pc_f=0x100 next cycle, flush_fd=1.
REQ-042 SHALL cover: redirect_jalr=1, target 0x201 -> pc_f=0x200, misalign_err=0; redirect target 0x202 -> pc_f held, misalign_err=1 for one cycle.
REQ-043 SHALL cover: trap_valid and redirect_valid together, trap_vec=0x80 -> pc_f=0x80.
REQ-044 SHALL cover: PC_BTB_EN, two taken updates for pc 0x40 -> 0x400 -> the next fetch of 0x40 gives pred_taken_f=1 and next pc_f=0x400; after two not-taken updates pred_taken_f=0.
REQ-045 SHALL cover: pc_f=0xFFFF_FFFC, no events -> next pc_f=0x0000_0000.
